// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, valid/ready fetch requests, in-order
// response buffering and branch redirect/flush for the control decoder.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        redirect_misal,
  input  logic        hold,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        stale
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  typedef enum logic {ST_BOOT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic            run;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     pc_q   [FIFO_DEPTH];

  logic [CW:0]     pending;
  logic            accept, rsp_take, drop_now, push, pop;
  logic            fifo_empty, fifo_full;
  logic [31:0]     redirect_base;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run = 1'b0;
    case (state_q)
      ST_RUN:  run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // Request channel: valid/ready. A transfer happens on a cycle where both are 1; once
  // raised, valid stays high and addr stays stable until accepted, unless a redirect
  // intervenes (valid drops that cycle and addr jumps to the new PC).
  always_comb begin
    pending       = {1'b0, count_q} + {1'b0, outstanding_q};
    fifo_empty    = (count_q == '0);
    fifo_full     = (count_q == FULL_CNT);
    redirect_base = {redirect_pc[31:2], 2'b00};

    imem_req_valid = run && (pending < DEPTH_W) && !redirect_valid;
    imem_req_addr  = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. straggling across a reset) are ignored.
    rsp_take = imem_rsp_valid && (outstanding_q != '0);
    drop_now = rsp_take && (drop_cnt_q != '0);
    push     = rsp_take && !drop_now && !redirect_valid;

    stale = fifo_empty || hold || redirect_valid;
    pop   = !stale;

    redirect_misal = redirect_valid && (redirect_pc[1:0] != 2'b00);
    instruction    = fifo_empty ? NOP : data_q[rd_ptr_q];
    instr_pc       = fifo_empty ? 32'h0 : pc_q[rd_ptr_q];
  end

  always_comb begin
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_take);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      // A response arriving alongside the redirect is already excluded from outstanding_d.
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (drop_now) drop_cnt_d = drop_cnt_q - CW'(1);
      if (accept)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= imem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full));

  a_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: one vector per clock cycle with
// hand-computed outputs, plus hand-written async reset sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_misal;
  logic        hold;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        stale;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_misal (redirect_misal),
    .hold           (hold),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .stale          (stale)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic        ready;
    logic        rsp_v;
    logic [31:0] rsp_a;    // address of the word returned (data = word_of(rsp_a))
    logic        redir;
    logic [31:0] rpc;
    logic        hold;
    logic        e_v;
    logic [31:0] e_addr;
    logic        e_stale;
    logic        e_head;   // FIFO non-empty: instruction = word_of(e_pc)
    logic [31:0] e_pc;
    logic        e_misal;
  } vec_t;

  vec_t vecs [64];
  int   nv;
  int   n_tests;
  int   n_fail;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  task automatic add(input logic ready, input logic rsp_v, input logic [31:0] rsp_a,
                     input logic redir, input logic [31:0] rpc, input logic hld,
                     input logic e_v, input logic [31:0] e_addr, input logic e_stale,
                     input logic e_head, input logic [31:0] e_pc, input logic e_misal);
    vecs[nv] = '{ready, rsp_v, rsp_a, redir, rpc, hld, e_v, e_addr, e_stale, e_head, e_pc, e_misal};
    nv++;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    hold           = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    @(negedge clk);
    imem_req_ready = vecs[i].ready;
    imem_rsp_valid = vecs[i].rsp_v;
    imem_rsp_data  = vecs[i].rsp_v ? word_of(vecs[i].rsp_a) : $urandom;
    redirect_valid = vecs[i].redir;
    redirect_pc    = vecs[i].rpc;
    hold           = vecs[i].hold;
    #1;
    check("req_valid", i, {31'b0, imem_req_valid}, {31'b0, vecs[i].e_v});
    check("req_addr",  i, imem_req_addr, vecs[i].e_addr);
    check("stale",     i, {31'b0, stale}, {31'b0, vecs[i].e_stale});
    check("instruction", i, instruction, vecs[i].e_head ? word_of(vecs[i].e_pc) : NOP);
    check("instr_pc",  i, instr_pc, vecs[i].e_head ? vecs[i].e_pc : 32'h0);
    check("misal",     i, {31'b0, redirect_misal}, {31'b0, vecs[i].e_misal});
  endtask

  task automatic check_reset_outputs(input int tag);
    check("rst_req_valid", tag, {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr",  tag, imem_req_addr, 32'h0);
    check("rst_misal",     tag, {31'b0, redirect_misal}, 32'h0);
    check("rst_stale",     tag, {31'b0, stale}, 32'h1);
    check("rst_instruction", tag, instruction, NOP);
    check("rst_instr_pc",  tag, instr_pc, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nv      = 0;
    rst_n   = 1'b0;
    drive_idle();

    // Startup, responses one cycle after acceptance (row 0 is the BOOT cycle).
    add(1,0,0,0,0,0,  0,32'h000, 1,0,32'h000, 0);
    add(1,0,0,0,0,0,  1,32'h000, 1,0,32'h000, 0);
    add(1,1,32'h000,0,0,0,  1,32'h004, 1,0,32'h000, 0);
    add(1,1,32'h004,0,0,0,  0,32'h008, 0,1,32'h000, 0);
    add(1,0,0,0,0,0,  1,32'h008, 0,1,32'h004, 0);
    add(1,1,32'h008,0,0,0,  1,32'h00C, 1,0,32'h000, 0);
    add(1,1,32'h00C,0,0,0,  0,32'h010, 0,1,32'h008, 0);
    add(1,0,0,0,0,0,  1,32'h010, 0,1,32'h00C, 0);
    // Memory not ready for 5 cycles: address held, FIFO drains.
    add(0,1,32'h010,0,0,0,  1,32'h014, 1,0,32'h000, 0);
    add(0,0,0,0,0,0,  1,32'h014, 0,1,32'h010, 0);
    add(0,0,0,0,0,0,  1,32'h014, 1,0,32'h000, 0);
    add(0,0,0,0,0,0,  1,32'h014, 1,0,32'h000, 0);
    add(0,0,0,0,0,0,  1,32'h014, 1,0,32'h000, 0);
    add(1,0,0,0,0,0,  1,32'h014, 1,0,32'h000, 0);
    add(1,1,32'h014,0,0,0,  1,32'h018, 1,0,32'h000, 0);
    add(1,1,32'h018,0,0,0,  0,32'h01C, 0,1,32'h014, 0);
    // Hold fills the FIFO, then 4 cycles held while full; nothing lost on release.
    add(1,0,0,0,0,1,  1,32'h01C, 1,1,32'h018, 0);
    add(1,1,32'h01C,0,0,1,  0,32'h020, 1,1,32'h018, 0);
    add(1,0,0,0,0,1,  0,32'h020, 1,1,32'h018, 0);
    add(1,0,0,0,0,1,  0,32'h020, 1,1,32'h018, 0);
    add(1,0,0,0,0,1,  0,32'h020, 1,1,32'h018, 0);
    add(1,0,0,0,0,1,  0,32'h020, 1,1,32'h018, 0);
    add(1,0,0,0,0,0,  0,32'h020, 0,1,32'h018, 0);
    add(1,0,0,0,0,0,  1,32'h020, 0,1,32'h01C, 0);
    add(1,1,32'h020,0,0,0,  1,32'h024, 1,0,32'h000, 0);
    add(1,0,0,0,0,0,  0,32'h028, 0,1,32'h020, 0);
    add(1,0,0,0,0,0,  1,32'h028, 1,0,32'h000, 0);
    // Redirect to 0x100 with two fetches (0x24, 0x28) in flight: both dropped.
    add(1,0,0,1,32'h100,0,  0,32'h02C, 1,0,32'h000, 0);
    add(1,1,32'h024,0,0,0,  0,32'h100, 1,0,32'h000, 0);
    add(1,1,32'h028,0,0,0,  1,32'h100, 1,0,32'h000, 0);
    add(1,1,32'h100,0,0,0,  1,32'h104, 1,0,32'h000, 0);
    add(1,1,32'h104,0,0,0,  0,32'h108, 0,1,32'h100, 0);
    add(1,0,0,0,0,0,  1,32'h108, 0,1,32'h104, 0);
    // Misaligned redirect with a response arriving in the same cycle (that word is dropped).
    add(1,1,32'h108,1,32'h203,0,  0,32'h10C, 1,0,32'h000, 1);
    add(1,0,0,0,0,0,  1,32'h200, 1,0,32'h000, 0);
    add(1,1,32'h200,0,0,0,  1,32'h204, 1,0,32'h000, 0);
    add(1,1,32'h204,0,0,0,  0,32'h208, 0,1,32'h200, 0);
    // hold+redirect, then a back-to-back redirect: the latest wins.
    add(1,0,0,1,32'h300,1,  0,32'h208, 1,1,32'h204, 0);
    add(1,0,0,1,32'h400,0,  0,32'h300, 1,0,32'h000, 0);
    add(1,0,0,0,0,0,  1,32'h400, 1,0,32'h000, 0);
    add(1,1,32'h400,0,0,0,  1,32'h404, 1,0,32'h000, 0);
    add(1,1,32'h404,0,0,0,  0,32'h408, 0,1,32'h400, 0);
    add(1,0,0,0,0,1,  1,32'h408, 1,1,32'h404, 0);
    add(1,1,32'h408,0,0,1,  0,32'h40C, 1,1,32'h404, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(-1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < nv; i++) apply_vec(i);

    // FIFO now full and held; then async reset mid-cycle with no clock edge.
    @(posedge clk);
    #2;
    check("full_req_valid", -2, {31'b0, imem_req_valid}, 32'h0);
    check("full_instr_pc",  -2, instr_pc, 32'h404);
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs(-3);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Restart from RESET_PC.
    for (int i = 0; i < 8; i++) apply_vec(i);

    @(negedge clk);
    drive_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
